// File: rtl/wrap_extend_counter.sv
// wrap_extend_counter: extends an upstream N-bit counter with a wrap-driven upper count,
// flagging any non-hold/non-step change on q_in as a sticky fault.
module wrap_extend_counter #(
  parameter int N = 3,
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               clear,
  input  logic [N-1:0]       q_in,
  input  logic               en,
  input  logic [WIDTH-1:0]   limit,
  input  logic               err_clr,
  output logic [WIDTH-1:0]   hi_cnt,
  output logic [WIDTH+N-1:0] full_cnt,
  output logic               wrap,
  output logic               tc,
  output logic               locked,
  output logic               err
);
  typedef enum logic [1:0] {SYNC, TRACK, FAULT} state_t;
  state_t state, state_nx;
  logic [N-1:0] q_prev;
  logic [WIDTH-1:0] hi_nx, top;
  logic wrap_nx, tc_nx, err_nx, hold, step, wrap_ev, roll;
  // limit 0 underflows to all-ones, which gives the natural 2^WIDTH modulo
  assign top = limit - WIDTH'(1);
  assign hold = q_in == q_prev;
  assign step = q_in == q_prev + N'(1);
  assign wrap_ev = step && q_in == '0;
  assign roll = en && hi_cnt >= top;
  assign full_cnt = {hi_cnt, q_prev};
  always_comb begin
    state_nx = state;
    hi_nx = hi_cnt;
    wrap_nx = 1'b0;
    tc_nx = 1'b0;
    err_nx = err;
    case (state)
      SYNC: state_nx = TRACK;
      TRACK:
        if (!hold && !step) begin
          state_nx = FAULT;
          err_nx = 1'b1;
        end else if (wrap_ev) begin
          wrap_nx = 1'b1;
          tc_nx = roll;
          hi_nx = roll ? '0 : hi_cnt + WIDTH'(en);
        end
      default:
        if (err_clr) begin
          state_nx = SYNC;
          err_nx = 1'b0;
        end
    endcase
  end
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state <= SYNC;
      q_prev <= '0;
      hi_cnt <= '0;
      wrap <= 1'b0;
      tc <= 1'b0;
      err <= 1'b0;
      locked <= 1'b0;
    end else begin
      state <= state_nx;
      q_prev <= q_in;
      hi_cnt <= hi_nx;
      wrap <= wrap_nx;
      tc <= tc_nx;
      err <= err_nx;
      locked <= state_nx == TRACK;
    end
  end
endmodule

// File: tb/tb_wrap_extend_counter.sv
// tb_wrap_extend_counter: random and directed stimulus against a behavioural model,
// expected outputs queued per edge and checked by an independent monitor.
`timescale 1ns/1ps
module tb_wrap_extend_counter;
  logic clk = 1'b0;
  logic clear = 1'b0;
  logic [2:0] q_in = '0;
  logic en = 1'b0;
  logic [3:0] limit = '0;
  logic err_clr = 1'b0;
  logic [3:0] hi_cnt;
  logic [6:0] full_cnt;
  logic wrap, tc, locked, err;
  wrap_extend_counter #(.N(3), .WIDTH(4)) dut (
    .clk(clk), .clear(clear), .q_in(q_in), .en(en), .limit(limit), .err_clr(err_clr),
    .hi_cnt(hi_cnt), .full_cnt(full_cnt), .wrap(wrap), .tc(tc), .locked(locked), .err(err)
  );
  always #5 clk = ~clk;
  logic [14:0] sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int mode = 0;
  int mhi = 0;
  int mqp = 0;
  int merr = 0;
  int cnt = 0;
  // Model: mode 0 = waiting to sync, 1 = tracking, 2 = faulted
  task automatic model(input int q, input bit e, input int l, input bit c);
    int d, md;
    bit w, t;
    w = 0;
    t = 0;
    if (mode == 0) mode = 1;
    else if (mode == 1) begin
      d = (q - mqp + 8) % 8;
      if (d > 1) begin
        mode = 2;
        merr = 1;
      end else if (d == 1 && q == 0) begin
        w = 1;
        if (e) begin
          md = (l == 0) ? 16 : l;
          if (mhi + 1 >= md) begin
            mhi = 0;
            t = 1;
          end else mhi = mhi + 1;
        end
      end
    end else if (c) begin
      mode = 0;
      merr = 0;
    end
    mqp = q;
    sb.push_back({4'(mhi), 4'(mhi), 3'(mqp), w, t, mode == 1, merr[0]});
  endtask
  task automatic tick(input int q, input bit e, input int l, input bit c);
    @(negedge clk);
    q_in = 3'(q);
    en = e;
    limit = 4'(l);
    err_clr = c;
    model(q, e, l, c);
  endtask
  task automatic run(input int n, input bit e, input int l);
    repeat (n) begin
      tick(cnt, e, l, 0);
      cnt = (cnt + 1) % 8;
    end
  endtask
  task automatic model_reset();
    mode = 0;
    mhi = 0;
    mqp = 0;
    merr = 0;
  endtask
  // Single checker: zeros while clear is low, otherwise the next queued expectation
  initial begin
    logic [14:0] exp_v, act_v;
    forever begin
      @(posedge clk or negedge clear);
      #1;
      act_v = {hi_cnt, full_cnt, wrap, tc, locked, err};
      if (!clear) begin
        n_cmp++;
        if (act_v !== '0) begin
          n_bad++;
          $display("FAIL reset_zero: got hi=%0d full=%0d w=%b tc=%b lk=%b err=%b, want all 0 at %0t",
                   hi_cnt, full_cnt, wrap, tc, locked, err, $time);
        end
      end else if (sb.size() > 0) begin
        exp_v = sb.pop_front();
        n_cmp++;
        if (act_v !== exp_v) begin
          n_bad++;
          $display("FAIL edge_out: got hi=%0d full=%0d w=%b tc=%b lk=%b err=%b, want hi=%0d full=%0d w=%b tc=%b lk=%b err=%b at %0t",
                   hi_cnt, full_cnt, wrap, tc, locked, err,
                   exp_v[14:11], exp_v[10:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0], $time);
        end
      end
    end
  end
  initial begin
    int r, lim, guard;
    bit e;
    repeat (2) @(posedge clk);
    #2 clear = 1'b1;
    model_reset();
    run(33, 1, 3);
    run(24, 0, 3);
    while (cnt != 5) run(1, 1, 3);
    repeat (4) tick(5, 1, 3, 0);
    cnt = 6;
    run(4, 1, 3);
    while (cnt != 3) run(1, 1, 3);
    tick(6, 1, 3, 0);
    cnt = 7;
    run(12, 1, 3);
    tick(cnt, 1, 3, 1);
    cnt = (cnt + 1) % 8;
    run(20, 1, 3);
    guard = 0;
    while (!(mhi == 2 && mqp == 5 && mode == 1) && guard < 200) begin
      run(1, 1, 3);
      guard++;
    end
    @(posedge clk);
    #3 clear = 1'b0;
    @(posedge clk);
    #2 clear = 1'b1;
    model_reset();
    run(12, 1, 3);
    run(16 * 8 + 8, 1, 0);
    guard = 0;
    while (mhi != 3 && guard < 100) begin
      run(1, 1, 5);
      guard++;
    end
    run(9, 1, 2);
    lim = 3;
    repeat (1500) begin
      r = $urandom_range(0, 99);
      e = $urandom_range(0, 9) < 8;
      if ($urandom_range(0, 49) == 0) lim = $urandom_range(0, 15);
      if (r < 2) begin
        cnt = (cnt + 2 + $urandom_range(0, 5)) % 8;
        tick(cnt, e, lim, 0);
        cnt = (cnt + 1) % 8;
      end else if (r < 14) tick((cnt + 7) % 8, e, lim, 0);
      else if (r < 20) begin
        tick(cnt, e, lim, 1);
        cnt = (cnt + 1) % 8;
      end else begin
        tick(cnt, e, lim, 0);
        cnt = (cnt + 1) % 8;
      end
    end
    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #3;
    if (sb.size() > 0) $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + sb.size());
    $finish;
  end
endmodule

// File: doc/wrap_extend_counter.md
Name: wrap_extend_counter

Overview:
- Downstream extension stage for the 3-bit free-running synchronous counter.
- Samples the counter's Q bus on the shared clock and detects each 7->0 wrap.
- Accumulates wraps into a programmable-modulo upper count and presents a combined wide count.
- Checks that the incoming count only holds or steps by +1; any other change latches a sticky fault.

Parameters:
- N, 3, width of incoming count from the upstream counter.
- WIDTH, 4, width of upper (wrap) count.

Ports:
- clk  input  1  rising-edge clock, shared with the upstream counter.
- clear  input  1  asynchronous active-low reset.
- q_in  input  N  count value from the upstream counter.
- en  input  1  allows upper count to advance on wrap.
- limit  input  WIDTH  upper-count modulo; 0 means natural 2^WIDTH.
- err_clr  input  1  clears a fault and forces resynchronisation.
- hi_cnt  output  WIDTH  upper count.
- full_cnt  output  WIDTH+N  {hi_cnt, q_prev}.
- wrap  output  1  one-cycle pulse per detected wrap.
- tc  output  1  one-cycle pulse when hi_cnt rolls over to 0.
- locked  output  1  high in TRACK state.
- err  output  1  sticky step-fault flag.

Behaviour:
- Reset: clear=0 asynchronously sets state=SYNC, q_prev=0, hi_cnt=0, wrap=0, tc=0, err=0, locked=0. This takes effect immediately, including mid-operation.
- All outputs are registered or are concatenations of registers. full_cnt is consistent: hi_cnt and q_prev update on the same edge.
- SYNC:
  - First rising edge with clear=1 does q_prev<=q_in, state<=TRACK.
  - No wrap, tc or err in SYNC.
- TRACK, every edge, q_prev<=q_in. Classify against q_prev:
  - hold: q_in==q_prev. No change.
  - step: q_in==(q_prev+1) mod 2^N.
  - wrap event: a step with q_prev==2^N-1 and q_in==0.
  - bad: anything else. state<=FAULT, err<=1, hi_cnt unchanged, no wrap/tc pulse.
- On a wrap event:
  - wrap<=1 for one cycle, regardless of en.
  - If en=1 and hi_cnt>=limit-1 (limit!=0): hi_cnt<=0, tc<=1.
  - If en=1 and limit==0: hi_cnt increments modulo 2^WIDTH; tc<=1 when it wraps from all-ones.
  - Otherwise, if en=1: hi_cnt<=hi_cnt+1.
  - en=0: hi_cnt holds, tc=0.
- limit changes take effect at the next wrap event. If limit is lowered below the current hi_cnt, that next wrap forces hi_cnt to 0 and pulses tc.
- limit==1: every enabled wrap pulses tc; hi_cnt stays 0.
- FAULT:
  - locked=0, err=1, hi_cnt frozen, wrap=tc=0.
  - q_prev continues to track q_in.
  - err_clr=1 at an edge: state<=SYNC, err<=0 on that edge.
  - err_clr in SYNC or TRACK is ignored.
- Latency: wrap and tc assert on the edge after the upstream counter presents 0, i.e. the same edge on which q_prev captures 0.
- Recovery: after SYNC the block relocks on the next edge; hi_cnt is preserved across a fault (only reset zeros it).

Test Plan:
1. Run the upstream counter (Q 0..7 repeating, one step per clk) with en=1, limit=3. Required:
   - wrap pulses every 8 cycles.
   - hi_cnt sequence 0,1,2,0.
   - tc pulses only on the 3rd wrap.
   - full_cnt counts 0..23 and returns to 0.
2. Same stimulus with en=0. Required: wrap pulses every 8 cycles, hi_cnt stays 0, tc stays 0, err stays 0.
3. Hold q_in=5 for 4 cycles, then resume with 6. Required: no err, locked stays 1, hi_cnt unchanged.
4. Jump q_in 2->6. Required:
   - Next edge: err=1, locked=0, hi_cnt frozen, no wrap pulses thereafter.
   - err_clr pulse: err=0, SYNC for one edge, then locked=1 and normal counting.
5. With hi_cnt=2 and q=5, assert clear between clock edges. Required:
   - All outputs 0 immediately, without waiting for a clock edge.
   - After release: first edge is SYNC (locked=0), second edge locked=1.
6. limit=0: tc fires on the 16th wrap with hi_cnt 15->0. Then set limit 5->2 while hi_cnt=3: next wrap gives hi_cnt=0 with a tc pulse.
